// File: rtl/vga_text_writer.sv
// vga_text_writer: command-driven text-cell writer into a VGA back buffer with clear and commit handshake
module vga_text_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_char,
  input  logic [23:0] cmd_color,
  input  logic [6:0]  cmd_col,
  input  logic [5:0]  cmd_row,
  input  logic        switch_buffer,
  output logic [12:0] vga_write_address,
  output logic [31:0] vga_data,
  output logic        vga_write_done,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, PUT, CLEAR, COMMIT_WAIT} state_t;
  localparam logic [6:0]  LC = 7'(COLS - 1);
  localparam logic [5:0]  LR = 6'(ROWS - 1);
  localparam logic [12:0] LN = 13'(COLS * ROWS - 1);
  state_t      r_state;
  logic [6:0]  r_col;
  logic [5:0]  r_row;
  logic [7:0]  r_char;
  logic [23:0] r_color;
  logic [12:0] r_clr;
  logic [12:0] r_addr;
  logic [31:0] r_data;
  logic        r_done;
  logic [12:0] w_cell;
  logic        w_eol;
  logic        w_last_row;
  logic [5:0]  w_next_row;
  assign w_cell     = 13'(r_row) * 13'(COLS) + 13'(r_col);
  assign w_eol      = r_col == LC;
  assign w_last_row = r_row == LR;
  assign w_next_row = w_last_row ? '0 : r_row + 6'd1;
  assign cmd_ready  = r_state == IDLE;
  assign busy       = r_state != IDLE;
  assign vga_write_address = r_addr;
  assign vga_data          = r_data;
  assign vga_write_done    = r_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_char  <= '0;
      r_color <= '0;
      r_clr   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (cmd_valid) begin
          case (cmd_op)
            2'b00: begin
              r_char  <= cmd_char;
              r_color <= cmd_color;
              if (cmd_char == 8'h0A) begin
                r_col <= '0;
                r_row <= w_next_row;
              end else r_state <= PUT;
            end
            2'b01: if (cmd_col <= LC && cmd_row <= LR) begin
              r_col <= cmd_col;
              r_row <= cmd_row;
            end
            2'b10: begin
              r_color <= cmd_color;
              r_clr   <= '0;
              r_state <= CLEAR;
            end
            default: begin
              r_done  <= 1'b1;
              r_state <= COMMIT_WAIT;
            end
          endcase
        end
        PUT: begin
          r_addr  <= w_cell;
          r_data  <= {r_char, r_color};
          r_col   <= w_eol ? '0 : r_col + 7'd1;
          r_row   <= w_eol ? w_next_row : r_row;
          r_state <= IDLE;
        end
        CLEAR: begin
          r_addr <= r_clr;
          r_data <= {8'h20, r_color};
          r_clr  <= r_clr + 13'd1;
          if (r_clr == LN) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        default: if (switch_buffer) begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vga_text_writer.sv
// tb_vga_text_writer: randomized scenario bench with a cursor/screen model of the text writer
module tb_vga_text_writer;
  localparam int COLS = 80;
  localparam int ROWS = 60;
  logic clk = 0, rst = 0, cmd_valid = 0, switch_buffer = 0;
  logic [1:0] cmd_op = 0;
  logic [7:0] cmd_char = 0;
  logic [23:0] cmd_color = 0;
  logic [6:0] cmd_col = 0;
  logic [5:0] cmd_row = 0;
  logic cmd_ready, vga_write_done, busy;
  logic [12:0] vga_write_address;
  logic [31:0] vga_data;
  int tests = 0, fails = 0;
  int mc = 0, mr = 0;
  int ea = 0;
  logic [31:0] ed = 0;

  vga_text_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_char(cmd_char), .cmd_color(cmd_color),
    .cmd_col(cmd_col), .cmd_row(cmd_row), .switch_buffer(switch_buffer),
    .vga_write_address(vga_write_address), .vga_data(vga_data),
    .vga_write_done(vga_write_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] op, input logic [7:0] ch, input logic [23:0] co,
                       input logic [6:0] c, input logic [5:0] r);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!cmd_ready) begin
      fails++;
      $display("FAIL issue_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    cmd_valid = 1; cmd_op = op; cmd_char = ch; cmd_color = co; cmd_col = c; cmd_row = r;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic model_put(input logic [7:0] ch, input logic [23:0] co);
    if (ch == 8'h0A) begin
      mc = 0;
      mr = (mr + 1) % ROWS;
    end else begin
      ea = mr * COLS + mc;
      ed = {ch, co};
      mc = mc + 1;
      if (mc == COLS) begin
        mc = 0;
        mr = (mr + 1) % ROWS;
      end
    end
  endtask

  task automatic put_check(input string name, input logic [7:0] ch, input logic [23:0] co);
    issue(2'b00, ch, co, 0, 0);
    if (ch != 8'h0A) @(negedge clk);
    model_put(ch, co);
    tests++;
    if (vga_write_address !== 13'(ea) || vga_data !== ed || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: addr=%0d data=%h busy=%b required addr=%0d data=%h busy=0",
               name, vga_write_address, vga_data, busy, ea, ed);
    end
  endtask

  task automatic set_cursor(input int c, input int r);
    issue(2'b01, 0, 0, 7'(c), 6'(r));
    if (c < COLS && r < ROWS) begin
      mc = c;
      mr = r;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    cmd_valid = 0;
    switch_buffer = 0;
    @(negedge clk);
    rst = 0;
    mc = 0; mr = 0; ea = 0; ed = 0;
  endtask

  task automatic check_idle_zero(input string name);
    tests++;
    if (vga_write_address !== 13'd0 || vga_data !== 32'd0 || vga_write_done !== 1'b0 ||
        busy !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s: addr=%0d data=%h done=%b busy=%b ready=%b required 0/0/0/0/1",
               name, vga_write_address, vga_data, vga_write_done, busy, cmd_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_zero("reset_state");
  endtask

  task automatic test_put();
    put_check("put_A", 8'h41, 24'hFF0000);
    tests++;
    if (vga_write_address !== 13'd0 || vga_data !== 32'h41FF0000) begin
      fails++;
      $display("FAIL put_A_const: addr=%0d data=%h required 0 41ff0000", vga_write_address, vga_data);
    end
    put_check("put_second", 8'h62, 24'h123456);
  endtask

  task automatic test_wrap();
    set_cursor(79, 59);
    put_check("put_last_cell", 8'h42, 24'h0000FF);
    tests++;
    if (vga_write_address !== 13'd4799) begin
      fails++;
      $display("FAIL last_cell_addr: addr=%0d required 4799", vga_write_address);
    end
    put_check("put_after_wrap", 8'h43, 24'hABCDEF);
  endtask

  task automatic test_invalid_cursor();
    set_cursor(10, 3);
    set_cursor(80, 5);
    put_check("bad_col_cursor", 8'h44, 24'h010203);
    set_cursor(5, 60);
    put_check("bad_row_cursor", 8'h45, 24'h040506);
  endtask

  task automatic test_newline();
    set_cursor(33, 59);
    put_check("newline_nowrite", 8'h0A, 24'hFFFFFF);
    put_check("newline_wrap_put", 8'h46, 24'h0A0B0C);
    set_cursor(7, 12);
    put_check("newline_mid", 8'h0A, 24'h0);
    put_check("newline_mid_put", 8'h47, 24'h0D0E0F);
  endtask

  task automatic test_clear();
    int bad = 0, busy_cnt = 0;
    set_cursor(20, 20);
    issue(2'b10, 8'h99, 24'h00FF00, 0, 0);
    for (int k = 1; k <= COLS * ROWS; k++) begin
      if (busy && !cmd_ready) busy_cnt++;
      @(negedge clk);
      if (bad == 0 && (vga_write_address !== 13'(k - 1) || vga_data !== 32'h2000FF00)) begin
        bad = k;
        $display("FAIL clear_write: step %0d addr=%0d data=%h required addr=%0d data=2000ff00",
                 k, vga_write_address, vga_data, k - 1);
      end
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (busy_cnt != COLS * ROWS || busy !== 1'b0) begin
      fails++;
      $display("FAIL clear_busy: busy cycles=%0d end busy=%b required %0d and 0", busy_cnt, busy, COLS * ROWS);
    end
    mc = 0; mr = 0; ea = COLS * ROWS - 1; ed = 32'h2000FF00;
    put_check("put_after_clear", 8'h48, 24'h112233);
  endtask

  task automatic test_commit();
    int bad = 0;
    @(negedge clk);
    switch_buffer = 1;
    @(negedge clk);
    switch_buffer = 0;
    tests++;
    if (vga_write_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL stray_switch: done=%b busy=%b required 0 0", vga_write_done, busy);
    end
    @(negedge clk);
    cmd_valid = 1; cmd_op = 2'b11; switch_buffer = 1;
    @(negedge clk);
    cmd_valid = 0; switch_buffer = 0;
    for (int k = 0; k < 10; k++) begin
      if (bad == 0 && (vga_write_done !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0)) begin
        bad = 1;
        $display("FAIL commit_hold: cycle %0d done=%b busy=%b ready=%b required 1 1 0",
                 k, vga_write_done, busy, cmd_ready);
      end
      if (k == 9) switch_buffer = 1;
      else @(negedge clk);
    end
    tests++;
    if (bad != 0) fails++;
    @(negedge clk);
    switch_buffer = 0;
    tests++;
    if (vga_write_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL commit_release: done=%b busy=%b required 0 0", vga_write_done, busy);
    end
    tests++;
    if (vga_write_address !== 13'(ea) || vga_data !== ed) begin
      fails++;
      $display("FAIL commit_persist: addr=%0d data=%h required %0d %h", vga_write_address, vga_data, ea, ed);
    end
    put_check("put_after_commit", 8'h49, 24'h445566);
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      int sel = $urandom_range(0, 9);
      if (sel < 3) set_cursor($urandom_range(0, 90), $urandom_range(0, 63));
      else if (sel == 3) put_check("rand_newline", 8'h0A, 24'($urandom));
      else begin
        logic [7:0] ch = 8'($urandom_range(32, 255));
        put_check("rand_put", ch, 24'($urandom));
      end
    end
  endtask

  task automatic test_reset_abort();
    issue(2'b10, 0, 24'h777777, 0, 0);
    repeat (100) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_idle_zero("rst_clear_abort");
    repeat (5) @(negedge clk);
    check_idle_zero("rst_clear_nowrite");
    mc = 0; mr = 0;
    issue(2'b11, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_idle_zero("rst_commit_abort");
    ea = 0; ed = 0;
    put_check("put_after_reset", 8'h4A, 24'h778899);
  endtask

  initial begin
    test_reset();
    test_put();
    test_wrap();
    test_invalid_cursor();
    test_newline();
    test_clear();
    test_commit();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
